// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the decode/execute/memory stage information that the hazard
// controller inspects, together with the stall/flush/freeze controls and the
// mult/div status it returns.
//
// Modports
//   master : pipeline side. Drives stage info, receives stall/flush/status.
//   slave  : controller side (pipe_hazard_ctrl). The opposite directions.
//
// Signals
//   D_rs_addr/D_rt_addr [4:0]  source registers of the instruction in D
//   D_rs_tuse/D_rt_tuse [1:0]  cycles until D needs the operand (3 = unused)
//   D_is_md                    D holds mult/div/mfhi/mflo/mthi/mtlo
//   E_wr_addr/M_wr_addr [4:0]  destination of E/M instruction (0 = none)
//   E_tnew/M_tnew       [1:0]  cycles until that result can be forwarded
//   E_md_start                 E holds a mult/div this cycle
//   E_md_is_div                1 = div/divu, 0 = mult/multu
//   ext_stall                  external freeze request
//   pc_stall/fd_stall          hold PC / FD register
//   de_flush                   insert bubble into DE
//   pipe_freeze                hold DE, EM and MW
//   md_busy/md_done            mult/div occupied / result-valid pulse
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  logic [4:0] D_rs_addr;
  logic [4:0] D_rt_addr;
  logic [1:0] D_rs_tuse;
  logic [1:0] D_rt_tuse;
  logic       D_is_md;
  logic [4:0] E_wr_addr;
  logic [1:0] E_tnew;
  logic [4:0] M_wr_addr;
  logic [1:0] M_tnew;
  logic       E_md_start;
  logic       E_md_is_div;
  logic       ext_stall;
  logic       pc_stall;
  logic       fd_stall;
  logic       de_flush;
  logic       pipe_freeze;
  logic       md_busy;
  logic       md_done;

  modport master (
    output D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, D_is_md,
    output E_wr_addr, E_tnew, M_wr_addr, M_tnew,
    output E_md_start, E_md_is_div, ext_stall,
    input  pc_stall, fd_stall, de_flush, pipe_freeze, md_busy, md_done
  );

  modport slave (
    input  D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, D_is_md,
    input  E_wr_addr, E_tnew, M_wr_addr, M_tnew,
    input  E_md_start, E_md_is_div, ext_stall,
    output pc_stall, fd_stall, de_flush, pipe_freeze, md_busy, md_done
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller for a 5-stage pipeline (PC, FD, DE, EM, MW).
//  - Detects RAW hazards that forwarding cannot cover (Tuse < Tnew).
//  - Tracks the multi-cycle mult/div unit with a two-state FSM and down-counter.
//  - Stalls PC/FD and bubbles DE on a hazard; an external stall freezes the
//    rest of the pipe and suppresses the bubble so no instruction is lost.
//
// Parameters
//   MULT_LAT : busy cycles for mult/multu (>=1)
//   DIV_LAT  : busy cycles for div/divu   (>=1, >=MULT_LAT)
//
// Ports
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   hif   : pipe_hazard_ctrl_if.slave (stage info in, stall/flush/status out)
//   stall_cnt[31:0], md_stall_cnt[31:0] : only with HAZARD_STATS_EN defined;
//     cycles with a hazard/mult-div stall that were not masked by ext_stall.
//
// Optional feature macro: HAZARD_STATS_EN (adds the two statistics counters).
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_ctrl_if.slave   hif
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         md_stall_cnt
`endif
);

  localparam int CW = $clog2(DIV_LAT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            md_done_reg, md_done_next;

  logic            hz;
  logic            mdz;
  logic            stall;

  // A consumer in D needs the operand in 'tuse' cycles; the producer can only
  // forward it in 'tnew' cycles. If tuse < tnew no forwarding path can help.
  // Register 0 never carries a real dependency.
  function automatic logic raw_hit(input logic [4:0] src, input logic [1:0] tuse,
                                   input logic [4:0] dst, input logic [1:0] tnew);
    return (src != 5'd0) && (src == dst) && (tuse < tnew);
  endfunction

  always_comb begin
    hz = raw_hit(hif.D_rs_addr, hif.D_rs_tuse, hif.E_wr_addr, hif.E_tnew)
       | raw_hit(hif.D_rt_addr, hif.D_rt_tuse, hif.E_wr_addr, hif.E_tnew)
       | raw_hit(hif.D_rs_addr, hif.D_rs_tuse, hif.M_wr_addr, hif.M_tnew)
       | raw_hit(hif.D_rt_addr, hif.D_rt_tuse, hif.M_wr_addr, hif.M_tnew);
  end

  // A mult/div-family instruction must wait while the unit is occupied, and
  // also during the cycle a new operation is being launched from E.
  assign mdz   = hif.D_is_md & ((state_reg == BUSY) | hif.E_md_start);
  assign stall = hz | mdz;

  assign hif.pc_stall    = stall | hif.ext_stall;
  assign hif.fd_stall    = stall | hif.ext_stall;
  // Freeze wins: while the pipe is frozen, DE holds its instruction instead of
  // taking a bubble, otherwise that instruction would be dropped.
  assign hif.de_flush    = stall & ~hif.ext_stall;
  assign hif.pipe_freeze = hif.ext_stall;
  assign hif.md_busy     = (state_reg == BUSY);
  assign hif.md_done     = md_done_reg;

  // Mult/div FSM state register. The unit runs independently of ext_stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      md_done_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      md_done_reg <= md_done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    md_done_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (hif.E_md_start) begin
          state_next = BUSY;
          cnt_next   = hif.E_md_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end
      end
      BUSY: begin
        if (cnt_reg == CW'(1)) begin
          md_done_next = 1'b1;
          // Back-to-back launch on the completing edge: stay busy with the
          // new latency; a start at any other busy edge is ignored.
          if (hif.E_md_start) begin
            state_next = BUSY;
            cnt_next   = hif.E_md_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef HAZARD_STATS_EN
  // Count only stalls that actually cost a bubble (not hidden under a freeze).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall & ~hif.ext_stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (mdz & ~hif.ext_stall) begin
        md_stall_cnt <= md_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed testbench for pipe_hazard_ctrl (default MULT_LAT=5, DIV_LAT=10).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit
// later, mid-cycle. "Cycle n" is the interval after edge n-1.
// With HAZARD_STATS_EN defined the statistics counters are checked as well.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] md_stall_cnt;
`endif

  pipe_hazard_ctrl_if hif ();

  pipe_hazard_ctrl #(
    .MULT_LAT(5),
    .DIV_LAT (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif.slave)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .md_stall_cnt (md_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hif.D_rs_addr   = 5'd0;
    hif.D_rt_addr   = 5'd0;
    hif.D_rs_tuse   = 2'd3;
    hif.D_rt_tuse   = 2'd3;
    hif.D_is_md     = 1'b0;
    hif.E_wr_addr   = 5'd0;
    hif.E_tnew      = 2'd0;
    hif.M_wr_addr   = 5'd0;
    hif.M_tnew      = 2'd0;
    hif.E_md_start  = 1'b0;
    hif.E_md_is_div = 1'b0;
    hif.ext_stall   = 1'b0;
  endtask

  task automatic chk_stall(input string tag, input logic pc, input logic de, input logic fr);
    chk({tag, "_pc_stall"}, {31'd0, hif.pc_stall}, {31'd0, pc});
    chk({tag, "_fd_stall"}, {31'd0, hif.fd_stall}, {31'd0, pc});
    chk({tag, "_de_flush"}, {31'd0, hif.de_flush}, {31'd0, de});
    chk({tag, "_freeze"},   {31'd0, hif.pipe_freeze}, {31'd0, fr});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    clear_inputs();

    // Reset state, with a start request that must be ignored during reset
    hif.E_md_start = 1'b1;
    repeat (2) next_cycle();
    hif.E_md_start = 1'b0;
    #1;
    chk("rst_md_busy", {31'd0, hif.md_busy}, 32'd0);
    chk("rst_md_done", {31'd0, hif.md_done}, 32'd0);
    chk_stall("rst", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    next_cycle();

    // Load-use: E produces r8 in 2 cycles, D needs it in 1
    hif.E_wr_addr = 5'd8; hif.E_tnew = 2'd2;
    hif.D_rs_addr = 5'd8; hif.D_rs_tuse = 2'd1;
    #1;
    chk_stall("loaduse", 1'b1, 1'b1, 1'b0);
    $display("load-use E r8 tnew2 rs tuse1: pc_stall=%0b de_flush=%0b", hif.pc_stall, hif.de_flush);

    // Tuse == Tnew is covered by forwarding
    hif.D_rs_tuse = 2'd2;
    #1;
    chk_stall("tuse_eq_tnew", 1'b0, 1'b0, 1'b0);
    $display("tuse=tnew=2: pc_stall=%0b", hif.pc_stall);

    // rt against E
    clear_inputs();
    hif.E_wr_addr = 5'd17; hif.E_tnew = 2'd1;
    hif.D_rt_addr = 5'd17; hif.D_rt_tuse = 2'd0;
    #1;
    chk_stall("rt_vs_e", 1'b1, 1'b1, 1'b0);
    $display("rt vs E r17: pc_stall=%0b", hif.pc_stall);

    // rs against M, address mismatch must not stall
    clear_inputs();
    hif.M_wr_addr = 5'd9; hif.M_tnew = 2'd1;
    hif.D_rs_addr = 5'd10; hif.D_rs_tuse = 2'd0;
    #1;
    chk_stall("addr_miss", 1'b0, 1'b0, 1'b0);
    hif.D_rs_addr = 5'd9;
    #1;
    chk_stall("rs_vs_m", 1'b1, 1'b1, 1'b0);
    $display("rs vs M r9: pc_stall=%0b", hif.pc_stall);

    // $0 guard
    clear_inputs();
    hif.E_wr_addr = 5'd0; hif.E_tnew = 2'd2;
    hif.D_rs_addr = 5'd0; hif.D_rs_tuse = 2'd0;
    #1;
    chk_stall("zero_reg", 1'b0, 1'b0, 1'b0);
    $display("$0 guard: pc_stall=%0b", hif.pc_stall);

    // Freeze with hazard: freeze wins, no bubble
    clear_inputs();
    hif.ext_stall = 1'b1;
    hif.M_wr_addr = 5'd4; hif.M_tnew = 2'd1;
    hif.D_rt_addr = 5'd4; hif.D_rt_tuse = 2'd0;
    #1;
    chk_stall("freeze_hz", 1'b1, 1'b0, 1'b1);
    $display("freeze+hazard: pc_stall=%0b de_flush=%0b freeze=%0b", hif.pc_stall, hif.de_flush, hif.pipe_freeze);

    // Freeze alone
    hif.M_wr_addr = 5'd0;
    #1;
    chk_stall("freeze_only", 1'b1, 1'b0, 1'b1);
    clear_inputs();
    next_cycle();

    // Mult: start at edge 0, md instr waiting in D
    hif.E_md_start = 1'b1; hif.E_md_is_div = 1'b0; hif.D_is_md = 1'b1;
    #1;
    chk("mul_c0_busy", {31'd0, hif.md_busy}, 32'd0);
    chk_stall("mul_c0", 1'b1, 1'b1, 1'b0);
    next_cycle();
    hif.E_md_start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("mul_c%0d_busy", c), {31'd0, hif.md_busy}, 32'd1);
      chk($sformatf("mul_c%0d_done", c), {31'd0, hif.md_done}, 32'd0);
      chk($sformatf("mul_c%0d_flush", c), {31'd0, hif.de_flush}, 32'd1);
      $display("mult cycle %0d: md_busy=%0b md_done=%0b", c, hif.md_busy, hif.md_done);
      next_cycle();
    end
    #1;
    chk("mul_c6_busy", {31'd0, hif.md_busy}, 32'd0);
    chk("mul_c6_done", {31'd0, hif.md_done}, 32'd1);
    chk("mul_c6_stall", {31'd0, hif.pc_stall}, 32'd0);
    $display("mult cycle 6: md_busy=%0b md_done=%0b", hif.md_busy, hif.md_done);
    next_cycle();
    #1;
    chk("mul_c7_done", {31'd0, hif.md_done}, 32'd0);
    clear_inputs();
    next_cycle();

    // Div then back-to-back mult launched on the completing edge 10
    hif.E_md_start = 1'b1; hif.E_md_is_div = 1'b1;
    next_cycle();
    hif.E_md_start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (c == 10) begin
        hif.E_md_start = 1'b1; hif.E_md_is_div = 1'b0;
      end
      if (c == 11) begin
        hif.E_md_start = 1'b0;
      end
      // Start inside the busy window (not on the completing edge) is ignored
      if (c == 5) hif.E_md_start = 1'b1;
      if (c == 6) hif.E_md_start = 1'b0;
      #1;
      chk($sformatf("div_c%0d_busy", c), {31'd0, hif.md_busy}, 32'd1);
      chk($sformatf("div_c%0d_done", c), {31'd0, hif.md_done}, (c == 11) ? 32'd1 : 32'd0);
      $display("div/b2b cycle %0d: md_busy=%0b md_done=%0b", c, hif.md_busy, hif.md_done);
      next_cycle();
    end
    #1;
    chk("b2b_c16_busy", {31'd0, hif.md_busy}, 32'd0);
    chk("b2b_c16_done", {31'd0, hif.md_done}, 32'd1);
    clear_inputs();
    next_cycle();
    next_cycle();

    // Reset in cycle 4 of a div
    hif.E_md_start = 1'b1; hif.E_md_is_div = 1'b1;
    next_cycle();
    hif.E_md_start = 1'b0;
    repeat (3) next_cycle();
    #1;
    chk("rdiv_c4_busy", {31'd0, hif.md_busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rdiv_busy_now", {31'd0, hif.md_busy}, 32'd0);
    chk("rdiv_done_now", {31'd0, hif.md_done}, 32'd0);
    $display("reset mid-div: md_busy=%0b md_done=%0b", hif.md_busy, hif.md_done);
`ifdef HAZARD_STATS_EN
    chk("rdiv_stall_cnt", stall_cnt, 32'd0);
    chk("rdiv_md_stall_cnt", md_stall_cnt, 32'd0);
`endif
    repeat (8) next_cycle();
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("rdiv_after%0d_done", c), {31'd0, hif.md_done}, 32'd0);
      chk($sformatf("rdiv_after%0d_busy", c), {31'd0, hif.md_busy}, 32'd0);
      next_cycle();
    end

`ifdef HAZARD_STATS_EN
    // 3 counted hazard edges, 1 masked by freeze, then 1 mult/div stall edge
    hif.E_wr_addr = 5'd8; hif.E_tnew = 2'd2;
    hif.D_rs_addr = 5'd8; hif.D_rs_tuse = 2'd1;
    repeat (3) next_cycle();
    hif.ext_stall = 1'b1;
    next_cycle();
    clear_inputs();
    hif.D_is_md = 1'b1; hif.E_md_start = 1'b1;
    next_cycle();
    clear_inputs();
    #1;
    chk("stats_stall_cnt", stall_cnt, 32'd4);
    chk("stats_md_stall_cnt", md_stall_cnt, 32'd1);
    $display("stats: stall_cnt=%0d md_stall_cnt=%0d", stall_cnt, md_stall_cnt);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
